// File: rtl/shreg_deser_if.sv
`default_nettype none
// ============================================================================
//  Module      : shreg_deser_if
//  Description : Output word stream of the deserializer. The FIFO head word
//                and its valid flag go downstream; ready comes back.
//  Ports       : o_data  - FIFO head word (WIDTH bits)
//                o_valid - FIFO non-empty
//                o_ready - downstream accepts o_data this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
interface shreg_deser_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] o_data;
  logic             o_valid;
  logic             o_ready;

  // The deserializer drives the word stream.
  modport master (
    output o_data,
    output o_valid,
    input  o_ready
  );

  // The downstream consumer.
  modport slave (
    input  o_data,
    input  o_valid,
    output o_ready
  );
endinterface
`default_nettype wire

// File: rtl/shreg_deser.sv
`default_nettype none
// ============================================================================
//  Module      : shreg_deser
//  Description : Serial-to-parallel capture stage. Hunts for the SYNC word in
//                the strobed bit stream, then packs the following bits
//                MSB-first into WIDTH-bit words. The words are buffered in a
//                DEPTH-entry FIFO and drained through valid/ready.
//  Ports       : clk      - clock, rising edge
//                rn       - asynchronous active-low reset
//                en       - bit strobe, d sampled only when en=1
//                d        - serial data bit
//                hunt     - drop lock and search for SYNC again
//                out_if   - word stream (o_data / o_valid / o_ready)
//                locked   - 1 while in the locked state
//                overflow - sticky, a finished word was dropped (FIFO full)
//                fill     - FIFO occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module shreg_deser #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] SYNC  = 8'hA5,
  parameter int               DEPTH = 4
) (
  input  wire logic                       clk,
  input  wire logic                       rn,
  input  wire logic                       en,
  input  wire logic                       d,
  input  wire logic                       hunt,
  shreg_deser_if.master                   out_if,
  output logic                            locked,
  output logic                            overflow,
  output logic [$clog2(DEPTH+1)-1:0]      fill
);

  localparam int CW = $clog2(WIDTH + 1);  // hunt counter, saturates at WIDTH
  localparam int BW = $clog2(WIDTH);      // bit counter, 0..WIDTH-1
  localparam int AW = $clog2(DEPTH);      // FIFO pointers
  localparam int FW = $clog2(DEPTH + 1);  // FIFO occupancy

  localparam logic [CW-1:0] c_HCNT_SAT  = CW'(WIDTH);
  localparam logic [CW-1:0] c_HCNT_ARM  = CW'(WIDTH - 1);
  localparam logic [BW-1:0] c_BIT_LAST  = BW'(WIDTH - 1);
  localparam logic [FW-1:0] c_FILL_FULL = FW'(DEPTH);

  typedef enum logic [0:0] {
    S_HUNT   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] window_q, window_d;
  logic [CW-1:0]    hcnt_q,   hcnt_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]    fill_q,   fill_d;
  logic             ovf_q,    ovf_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [WIDTH-1:0] w_win;
  logic             w_pop;
  logic             w_push;
  logic             w_push_ok;

  // Window as it will look after shifting in the current bit.
  assign w_win = {window_q[WIDTH-2:0], d};

  // --------------------------------------------------------------------------
  // Next-state and FIFO control
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    window_d  = window_q;
    hcnt_d    = hcnt_q;
    bitcnt_d  = bitcnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    fill_d    = fill_q;
    ovf_d     = ovf_q;
    w_push    = 1'b0;
    w_push_ok = 1'b0;
    w_pop     = (fill_q != '0) & out_if.o_ready;

    if (hunt) begin
      // Any bit strobed on this edge is discarded along with the partial word.
      state_d  = S_HUNT;
      hcnt_d   = '0;
      bitcnt_d = '0;
      ovf_d    = 1'b0;
    end else if (en) begin
      window_d = w_win;
      case (state_q)
        S_HUNT: begin
          // hcnt_q counts bits already taken; at WIDTH-1 this edge fills the
          // window with bits received entirely since entering HUNT.
          if ((hcnt_q >= c_HCNT_ARM) && (w_win == SYNC)) begin
            state_d  = S_LOCKED;
            bitcnt_d = '0;
          end
          if (hcnt_q != c_HCNT_SAT) begin
            hcnt_d = hcnt_q + CW'(1);
          end
        end
        S_LOCKED: begin
          if (bitcnt_q == c_BIT_LAST) begin
            bitcnt_d = '0;
            w_push   = 1'b1;
          end else begin
            bitcnt_d = bitcnt_q + BW'(1);
          end
        end
        default: begin
          state_d = S_HUNT;
        end
      endcase
    end

    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    w_push_ok = w_push & ((fill_q != c_FILL_FULL) | w_pop);
    if (w_push & ~w_push_ok) begin
      ovf_d = 1'b1;
    end

    if (w_push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({w_push_ok, w_pop})
      2'b10:   fill_d = fill_q + FW'(1);
      2'b01:   fill_d = fill_q - FW'(1);
      default: fill_d = fill_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      state_q  <= S_HUNT;
      window_q <= '0;
      hcnt_q   <= '0;
      bitcnt_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      window_q <= window_d;
      hcnt_q   <= hcnt_d;
      bitcnt_q <= bitcnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage needs no reset: the head word is masked while empty.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      mem_q[wr_ptr_q] <= w_win;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs, all decoded from registers
  // --------------------------------------------------------------------------
  assign out_if.o_valid = (fill_q != '0);
  assign out_if.o_data  = (fill_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign locked         = (state_q == S_LOCKED);
  assign overflow       = ovf_q;
  assign fill           = fill_q;

endmodule
`default_nettype wire
